// File: rtl/div_result_display.sv
// Seven-segment display stage for the 4-bit divider result: captures on load, scans four digits, shows "Err".
// Optional macro DIV_DISP_BLINK_EN makes the "Err" display blink.
module div_result_display #(
    parameter int unsigned SCAN_DIV  = 1000,
    parameter int unsigned BLINK_DIV = 64
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [3:0] Quotient,
    input  logic [3:0] Remainder,
    input  logic       Error,
    input  logic       Fractional,
    output logic [6:0] seg,
    output logic [3:0] an,
    output logic       dp,
    output logic       valid
);

    localparam int unsigned PRESC_W = $clog2(SCAN_DIV);
    localparam logic [6:0]  BLANK   = 7'h7F;
    localparam logic [6:0]  GLYPH_E = 7'h06;
    localparam logic [6:0]  GLYPH_R = 7'h2F;

    typedef enum logic [1:0] {IDLE, SHOW, ERR} state_t;

    state_t               state_q, state_d;
    logic [3:0]           q_q, q_d;
    logic [3:0]           r_q, r_d;
    logic                 frac_q, frac_d;
    logic [PRESC_W-1:0]   presc_q, presc_d;
    logic [1:0]           dig_q, dig_d;
    logic [6:0]           seg_q, seg_d;
    logic [3:0]           an_q, an_d;
    logic                 dp_q, dp_d;
    logic                 valid_q, valid_d;

`ifdef DIV_DISP_BLINK_EN
    localparam int unsigned FRAME_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    logic [FRAME_W-1:0]   frame_q, frame_d;
    logic                 blink_on_q, blink_on_d;
`endif

    logic                 q_tens, r_tens;
    logic [3:0]           q_units, r_units;

    // Active-low 0-9 patterns, seg[0]=a .. seg[6]=g.
    function automatic logic [6:0] glyph(input logic [3:0] d);
        case (d)
            4'd0:    glyph = 7'h40;
            4'd1:    glyph = 7'h79;
            4'd2:    glyph = 7'h24;
            4'd3:    glyph = 7'h30;
            4'd4:    glyph = 7'h19;
            4'd5:    glyph = 7'h12;
            4'd6:    glyph = 7'h02;
            4'd7:    glyph = 7'h78;
            4'd8:    glyph = 7'h00;
            4'd9:    glyph = 7'h10;
            default: glyph = BLANK;
        endcase
    endfunction

    // Next-state: capture on load, otherwise advance the scan while a result is shown.
    always_comb begin
        state_d = state_q;
        q_d     = q_q;
        r_d     = r_q;
        frac_d  = frac_q;
        presc_d = presc_q;
        dig_d   = dig_q;
`ifdef DIV_DISP_BLINK_EN
        frame_d    = frame_q;
        blink_on_d = blink_on_q;
`endif
        if (load) begin
            state_d = Error ? ERR : SHOW;
            q_d     = Quotient;
            r_d     = Remainder;
            frac_d  = Fractional;
            presc_d = '0;
            dig_d   = 2'd3;
`ifdef DIV_DISP_BLINK_EN
            frame_d    = '0;
            blink_on_d = 1'b1;
`endif
        end else if (state_q != IDLE) begin
            if (presc_q == PRESC_W'(SCAN_DIV - 1)) begin
                presc_d = '0;
                dig_d   = dig_q - 2'd1;
`ifdef DIV_DISP_BLINK_EN
                if (dig_q == 2'd0) begin
                    if (frame_q == FRAME_W'(BLINK_DIV - 1)) begin
                        frame_d    = '0;
                        blink_on_d = ~blink_on_q;
                    end else begin
                        frame_d = frame_q + FRAME_W'(1);
                    end
                end
`endif
            end else begin
                presc_d = presc_q + PRESC_W'(1);
            end
        end
    end

    assign q_tens  = (q_d >= 4'd10);
    assign r_tens  = (r_d >= 4'd10);
    assign q_units = q_tens ? (q_d - 4'd10) : q_d;
    assign r_units = r_tens ? (r_d - 4'd10) : r_d;

    // Output decode from next-state values so anode and segments land on the same edge.
    always_comb begin
        seg_d   = BLANK;
        an_d    = 4'hF;
        dp_d    = 1'b1;
        valid_d = 1'b0;
        case (state_d)
            SHOW: begin
                valid_d = 1'b1;
                an_d    = ~(4'b0001 << dig_d);
                case (dig_d)
                    2'd3: seg_d = q_tens ? glyph(4'd1) : BLANK;
                    2'd2: begin
                        seg_d = glyph(q_units);
                        dp_d  = ~frac_d;
                    end
                    2'd1: seg_d = r_tens ? glyph(4'd1) : BLANK;
                    default: seg_d = glyph(r_units);
                endcase
            end
            ERR: begin
                valid_d = 1'b1;
                an_d    = ~(4'b0001 << dig_d);
                case (dig_d)
                    2'd3:    seg_d = GLYPH_E;
                    2'd2:    seg_d = GLYPH_R;
                    2'd1:    seg_d = GLYPH_R;
                    default: seg_d = BLANK;
                endcase
`ifdef DIV_DISP_BLINK_EN
                if (!blink_on_d) begin
                    an_d  = 4'hF;
                    seg_d = BLANK;
                end
`endif
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            q_q     <= '0;
            r_q     <= '0;
            frac_q  <= 1'b0;
            presc_q <= '0;
            dig_q   <= 2'd3;
            seg_q   <= BLANK;
            an_q    <= 4'hF;
            dp_q    <= 1'b1;
            valid_q <= 1'b0;
`ifdef DIV_DISP_BLINK_EN
            frame_q    <= '0;
            blink_on_q <= 1'b1;
`endif
        end else begin
            state_q <= state_d;
            q_q     <= q_d;
            r_q     <= r_d;
            frac_q  <= frac_d;
            presc_q <= presc_d;
            dig_q   <= dig_d;
            seg_q   <= seg_d;
            an_q    <= an_d;
            dp_q    <= dp_d;
            valid_q <= valid_d;
`ifdef DIV_DISP_BLINK_EN
            frame_q    <= frame_d;
            blink_on_q <= blink_on_d;
`endif
        end
    end

    assign seg   = seg_q;
    assign an    = an_q;
    assign dp    = dp_q;
    assign valid = valid_q;

endmodule

// File: doc/div_result_display.md
# div_result_display

Sequential output stage that sits directly downstream of the 4-bit divider in the ULA datapath. It captures Quotient, Remainder, Error and Fractional on a load strobe and holds them. It converts each 4-bit value to two decimal digits and time-multiplexes four common-anode seven-segment digits. An error is shown as "Err", optionally blinking.

## Interface
Parameters:
- SCAN_DIV, default 1000: clock cycles each digit stays enabled; legal range ≥ 2.
- BLINK_DIV, default 64: full scan frames per blink half-period; legal range ≥ 1.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- load  in  1  capture strobe, sampled on the rising edge of clk.
- Quotient  in  4  divider quotient.
- Remainder  in  4  divider remainder.
- Error  in  1  divide-by-zero flag.
- Fractional  in  1  non-zero-remainder flag.
- seg  out  7  active-low segments; seg[0]=a … seg[6]=g.
- an  out  4  active-low digit enables; an[3] is the leftmost digit.
- dp  out  1  active-low decimal point.
- valid  out  1  high while a captured result is displayed.

## Operation
- FSM states and transitions:
  - IDLE is entered on reset. In IDLE the display is blank and valid=0.
  - load with Error=1 goes to ERR from any state.
  - load with Error=0 goes to SHOW from any state.
  - There is no other exit from SHOW or ERR. Only another load or a reset changes state.
- Capture: when load=1 at a rising edge, the Quotient, Remainder, Error and Fractional inputs are registered. The registers hold until the next load. Input changes between loads are ignored.
- Digit mapping in SHOW:
  - an[3] shows Q tens.
  - an[2] shows Q units.
  - an[1] shows R tens.
  - an[0] shows R units.
- Decimal conversion: tens = (v ≥ 10), units = v − 10·tens.
- Leading-zero blanking: a tens digit equal to 0 is blanked (seg=7'h7F) while its anode is still driven.
- dp is low only while an[2] is active in SHOW with captured Fractional=1. In every other case dp is high.
- ERR display: an[3]="E", an[2]="r", an[1]="r", an[0]=blank. Fractional is ignored. Error takes precedence over Quotient and Remainder.
- Glyphs:
  - Standard 0–9 patterns.
  - "E" lights segments a, d, e, f, g.
  - "r" lights segments e, g.
  - Blank is all segments off.
- Scan:
  - The prescaler counts 0…SCAN_DIV−1.
  - At terminal count the digit index steps 3→2→1→0→3.
  - Exactly one an bit is low in SHOW and ERR. In IDLE all an bits are high.
- Blink:
  - The frame counter advances once per completed digit-0 slot, counting 0…BLINK_DIV−1.
  - At its terminal count the blink phase toggles.

## Timing
- Reset values, asserted asynchronously and immediately:
  - Outputs: seg=7'h7F, an=4'hF, dp=1, valid=0.
  - Internal: state=IDLE, all counters 0, digit index=3, blink phase=on.
  - Reset mid-scan or mid-blink takes effect immediately; no partial frame completes.
- Load latency:
  - Registers update on the load edge.
  - On the following cycle: valid=1, an=4'b0111 (digit 3), prescaler=0, frame counter=0, blink phase=on.
  - Every load restarts the scan, including a load while already in SHOW or ERR.
- Load held high: the inputs are recaptured each cycle and the scan stays pinned at digit 3 with prescaler 0.
- Digit period is SCAN_DIV cycles; frame period is 4·SCAN_DIV cycles.
- Blink half-period is BLINK_DIV·4·SCAN_DIV cycles.
- Outputs are registered. seg, an and dp change together on the same edge, with no one-cycle skew between anode and segment.

## Configuration
- Macro DIV_DISP_BLINK_EN.
- Defined: in ERR, during blink phase "off" all of an are high. SHOW never blinks.
- Undefined: ERR is shown steady. The blink phase register and frame counter are not built.

## Test plan
Bench runs with SCAN_DIV=4 and BLINK_DIV=2.
- Reset then idle: assert rst for 3 cycles, release, run 50 cycles → seg=7'h7F, an=4'hF, dp=1, valid=0 throughout.
- Show 13 rem 2: load with Q=13, R=2, E=0, F=1 → valid=1 next cycle. The digit sequence repeats every 16 cycles with 4 cycles per digit:
  - an=0111 shows "1".
  - an=1011 shows "3" with dp=0.
  - an=1101 shows blank.
  - an=1110 shows "2".
- Zero and blanking: load Q=0, R=15, F=0 → an[3] slot is blank, an[2] shows "0", an[1] shows "1", an[0] shows "5", and dp is always 1.
- Error, macro defined: load E=1, Q=5 → "E", "r", "r", blank. After 32 cycles, all an bits are high for 32 cycles, then the display returns.
- Error, macro undefined: the same stimulus shows steady "Err" for 200 cycles.
- Reload and async reset: load a new value mid-digit-1 → scan restarts at an=0111 the next cycle. Assert rst mid-cycle → outputs return to reset values before the next clock edge.
